reg_hazard_scoreboard: RTL

Parametrised register-hazard scoreboard for the decode stage of the in-order RISC-V pipeline. It tracks every in-flight architectural destination register with a per-register countdown until its result is forwardable. From that state it generates the decode stall for RAW hazards and for WAW hazards involving multi-cycle units. It replaces the fixed load-use stall equations in decode, supports any per-instruction result latency up to MAX_LAT, and counts stall cycles.

---
 rtl/reg_hazard_scoreboard.sv | 132 +++++++++++++
 1 files changed

// File: rtl/reg_hazard_scoreboard.sv
// Register-hazard scoreboard for decode: per-register result countdowns,
// RAW/WAW stall generation and a saturating stall-cycle counter.

// One countdown per architectural register.
module reg_hazard_cnt #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             ld,
  input  logic [LAT_W-1:0] ld_val,
  output logic [LAT_W-1:0] cnt
);

  // A new writer reloads the entry; otherwise it counts down towards forwardable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (adv) begin
      if (ld)            cnt <= ld_val;
      else if (cnt != 0) cnt <= cnt - 1'b1;
    end
  end

endmodule

module reg_hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_LAT  = 4,
  parameter int LAT_W    = $clog2(MAX_LAT+1),
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [IDX_W-1:0]    id_rs1_idx,
  input  logic                id_rs1_used,
  input  logic [IDX_W-1:0]    id_rs2_idx,
  input  logic                id_rs2_used,
  input  logic [IDX_W-1:0]    id_rd_idx,
  input  logic                id_reg_wr,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                advance,
  input  logic                flush,
  input  logic                perf_clr,
  output logic                stall,
  output logic                issue,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    stall_count
);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] rs1;
    logic             rs1_used;
    logic [IDX_W-1:0] rs2;
    logic             rs2_used;
    logic [IDX_W-1:0] rd;
    logic             reg_wr;
    logic [LAT_W-1:0] lat;
  } id_req_t;

  id_req_t req;
  assign req = '{valid: id_valid, rs1: id_rs1_idx, rs1_used: id_rs1_used,
                 rs2: id_rs2_idx, rs2_used: id_rs2_used, rd: id_rd_idx,
                 reg_wr: id_reg_wr, lat: id_lat};

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [LAT_W-1:0] lat_eff, ld_val;
  logic [LAT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic             waw, wr_en;

  // Effective latency: 0 means single-cycle, anything past MAX_LAT is the slowest unit.
  always_comb begin
    lat_eff = req.lat;
    if (req.lat == '0)                     lat_eff = LAT_W'(1);
    else if (req.lat > LAT_W'(MAX_LAT))    lat_eff = LAT_W'(MAX_LAT);
  end

  assign ld_val = lat_eff - LAT_W'(1);

  // Read the source/destination countdowns; x0 and out-of-range indices read as 0.
  always_comb begin
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    cnt_rd  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (req.rs1 == IDX_W'(r)) cnt_rs1 = cnt[r];
      if (req.rs2 == IDX_W'(r)) cnt_rs2 = cnt[r];
      if (req.rd  == IDX_W'(r)) cnt_rd  = cnt[r];
    end
  end

  assign rs1_busy = req.valid & req.rs1_used & (req.rs1 != '0) & (cnt_rs1 != '0);
  assign rs2_busy = req.valid & req.rs2_used & (req.rs2 != '0) & (cnt_rs2 != '0);
  // The older writer must retire strictly before the new one, else results reorder.
  assign waw      = req.valid & req.reg_wr & (req.rd != '0) & (cnt_rd != '0) &
                    (cnt_rd >= ld_val);
  assign stall    = rs1_busy | rs2_busy | waw;
  assign issue    = req.valid & ~stall & advance & ~flush;
  assign wr_en    = issue & req.reg_wr;

  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_reg
      reg_hazard_cnt #(.LAT_W(LAT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .adv    (advance),
        .ld     (wr_en & (req.rd == IDX_W'(g))),
        .ld_val (ld_val),
        .cnt    (cnt[g])
      );
      assign busy_vec[g] = |cnt[g];
    end
  endgenerate

  // Stall-cycle counter: freeze and flushed cycles are not counted; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      stall_count <= '0;
    else if (perf_clr)                            stall_count <= '0;
    else if (req.valid & stall & advance & ~flush & ~&stall_count)
                                                  stall_count <= stall_count + 1'b1;
  end

endmodule
